// File: rtl/trace_cmd_sink_if.sv
// Trace-word input stream and decoded-operation output stream of trace_cmd_sink.
// Width parameters must match the ones given to the sink instance.
interface trace_cmd_sink_if #(
    parameter int CMD_W    = 4,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 14
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    logic                in_valid;
    logic                in_ready;
    logic [CMD_W-1:0]    in_cmd;
    logic [ADDR_W-1:0]   in_addr;
    logic                in_eof;

    logic                out_valid;
    logic                out_ready;
    logic [2:0]          out_op;
    logic [TAG_W-1:0]    out_tag;
    logic [INDEX_W-1:0]  out_index;
    logic [OFFSET_W-1:0] out_offset;

    // Trace source plus cache side.
    modport master (
        output in_valid, in_cmd, in_addr, in_eof, out_ready,
        input  in_ready, out_valid, out_op, out_tag, out_index, out_offset
    );

    modport slave (
        input  in_valid, in_cmd, in_addr, in_eof, out_ready,
        output in_ready, out_valid, out_op, out_tag, out_index, out_offset
    );
endinterface

// File: rtl/trace_cmd_sink.sv
// Trace command sink: decodes trace words, drops illegal codes, queues decoded
// operations in a small FIFO and drains it once the trace source reports end-of-file.
module trace_cmd_sink #(
    parameter int CMD_W    = 4,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 14,
    parameter int DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    trace_cmd_sink_if.slave      bus,
    output logic                 err_illegal,
    output logic [15:0]          cnt_total,
    output logic [7:0]           cnt_illegal,
    output logic                 done
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = 3 + ADDR_W;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic              err_q, err_d;
    logic [15:0]       tot_q, tot_d;
    logic [7:0]        ill_q, ill_d;

    logic [ENT_W-1:0]  slot [DEPTH];
    logic [ENT_W-1:0]  head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              out_valid_w;
    logic              in_ready_w;
    logic              accept;
    logic              push;
    logic              pop;
    logic              legal;
    logic [2:0]        dec_op;

    always_comb begin
        dec_op = 3'd0;
        legal  = 1'b0;
        case (bus.in_cmd)
            CMD_W'(0): begin dec_op = 3'd0; legal = 1'b1; end
            CMD_W'(1): begin dec_op = 3'd1; legal = 1'b1; end
            CMD_W'(2): begin dec_op = 3'd2; legal = 1'b1; end
            CMD_W'(3): begin dec_op = 3'd3; legal = 1'b1; end
            CMD_W'(4): begin dec_op = 3'd4; legal = 1'b1; end
            CMD_W'(8): begin dec_op = 3'd5; legal = 1'b1; end
            CMD_W'(9): begin dec_op = 3'd6; legal = 1'b1; end
            default:   begin dec_op = 3'd0; legal = 1'b0; end
        endcase
    end

    // Pointers carry one extra wrap bit so equal low bits mean empty or full.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // Readiness depends on registered state only, so a same-cycle pop never frees a slot early;
    // it is also held low while reset is asserted.
    assign in_ready_w  = rst_n && (state_q == ST_RUN) && !fifo_full;
    assign out_valid_w = !fifo_empty && (state_q != ST_DONE);
    assign accept      = bus.in_valid && in_ready_w;
    assign push        = accept && legal;
    assign pop         = out_valid_w && bus.out_ready;

    assign wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
    assign rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (bus.in_eof) state_d = ST_DRAIN;
            ST_DRAIN: if (wr_ptr_d == rd_ptr_d) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        err_d = accept && !legal;
        tot_d = tot_q;
        ill_d = ill_q;
        if (push && (tot_q != 16'hFFFF)) tot_d = tot_q + 16'd1;
        if (accept && !legal && (ill_q != 8'hFF)) ill_d = ill_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
            tot_q    <= '0;
            ill_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
            tot_q    <= tot_d;
            ill_q    <= ill_d;
        end
    end

    // Storage needs no reset: nothing is visible until the pointers say it was written.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [ENT_W-1:0] entry_q;
        logic [ENT_W-1:0] entry_d;

        always_comb begin
            entry_d = entry_q;
            if (push && (wr_ptr_q[PTR_W-1:0] == PTR_W'(gi))) entry_d = {dec_op, bus.in_addr};
        end

        always_ff @(posedge clk) begin
            entry_q <= entry_d;
        end

        assign slot[gi] = entry_q;
    end

    assign head = slot[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        bus.out_op     = '0;
        bus.out_tag    = '0;
        bus.out_index  = '0;
        bus.out_offset = '0;
        if (out_valid_w) begin
            bus.out_op     = head[ENT_W-1 -: 3];
            bus.out_tag    = head[ADDR_W-1 -: TAG_W];
            bus.out_index  = head[OFFSET_W +: INDEX_W];
            bus.out_offset = head[OFFSET_W-1:0];
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign err_illegal   = err_q;
    assign cnt_total     = tot_q;
    assign cnt_illegal   = ill_q;
    assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_trace_cmd_sink.sv
// Directed-plus-random bench for trace_cmd_sink against a queue-based reference model.
module tb_trace_cmd_sink;
    localparam int CMD_W    = 4;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 6;
    localparam int INDEX_W  = 14;
    localparam int DEPTH    = 4;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_DONE  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        err_illegal;
    logic [15:0] cnt_total;
    logic [7:0]  cnt_illegal;
    logic        done;

    trace_cmd_sink_if #(.CMD_W(CMD_W), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W)) bus ();

    trace_cmd_sink #(
        .CMD_W(CMD_W), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .err_illegal(err_illegal),
        .cnt_total(cnt_total),
        .cnt_illegal(cnt_illegal),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          op;
        logic [31:0] addr;
    } ent_t;

    ent_t q[$];
    int   m_state;
    int   m_tot;
    int   m_ill;
    bit   m_err;
    int   n_vec = 0;
    int   n_err = 0;

    int legal_codes[7]   = '{0, 1, 2, 3, 4, 8, 9};
    int illegal_codes[9] = '{5, 6, 7, 10, 11, 12, 13, 14, 15};

    function automatic int op_of(input int cmd);
        case (cmd)
            0, 1, 2, 3, 4: return cmd;
            8:             return 5;
            9:             return 6;
            default:       return -1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_state = M_RUN;
        m_tot   = 0;
        m_ill   = 0;
        m_err   = 1'b0;
    endfunction

    task automatic check_all();
        logic [31:0] a;
        chk("in_ready", {31'd0, bus.in_ready},
            {31'd0, (rst_n === 1'b1) && (m_state == M_RUN) && (q.size() < DEPTH)});
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
        chk("err_illegal", {31'd0, err_illegal}, {31'd0, m_err});
        chk("cnt_total", {16'd0, cnt_total}, m_tot);
        chk("cnt_illegal", {24'd0, cnt_illegal}, m_ill);
        chk("done", {31'd0, done}, {31'd0, m_state == M_DONE});
        if (q.size() != 0) begin
            a = q[0].addr;
            chk("out_op", {29'd0, bus.out_op}, q[0].op);
            chk("out_tag", {{(32-TAG_W){1'b0}}, bus.out_tag}, a >> (OFFSET_W + INDEX_W));
            chk("out_index", {{(32-INDEX_W){1'b0}}, bus.out_index}, (a >> OFFSET_W) % (32'd1 << INDEX_W));
            chk("out_offset", {{(32-OFFSET_W){1'b0}}, bus.out_offset}, a % (32'd1 << OFFSET_W));
        end
    endtask

    // Check outputs against the model, apply one clock edge to both, land 1 ns after it.
    task automatic step();
        bit   rdy;
        bit   acc;
        int   op;
        ent_t e;
        check_all();
        rdy = (m_state == M_RUN) && (q.size() < DEPTH);
        acc = rdy && (bus.in_valid === 1'b1);
        op  = op_of(int'(bus.in_cmd));
        if ((q.size() != 0) && (bus.out_ready === 1'b1)) void'(q.pop_front());
        m_err = acc && (op < 0);
        if (acc && (op >= 0)) begin
            e.op   = op;
            e.addr = bus.in_addr;
            q.push_back(e);
            if (m_tot < 65535) m_tot++;
        end
        if (acc && (op < 0) && (m_ill < 255)) m_ill++;
        if ((m_state == M_RUN) && (bus.in_eof === 1'b1)) m_state = M_DRAIN;
        else if ((m_state == M_DRAIN) && (q.size() == 0)) m_state = M_DONE;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int cmd, input logic [31:0] addr);
        bus.in_valid = v;
        bus.in_cmd   = CMD_W'(cmd);
        bus.in_addr  = addr;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_out_op", {29'd0, bus.out_op}, 0);
        chk("rst_out_tag", {{(32-TAG_W){1'b0}}, bus.out_tag}, 0);
        chk("rst_out_index", {{(32-INDEX_W){1'b0}}, bus.out_index}, 0);
        chk("rst_out_offset", {{(32-OFFSET_W){1'b0}}, bus.out_offset}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_rst", {31'd0, bus.in_ready}, 1);
    endtask

    initial begin
        drive(1'b0, 0, 32'd0);
        bus.in_eof    = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        #3;
        do_reset();

        // Address split of a known word.
        bus.out_ready = 1'b1;
        drive(1'b1, 0, 32'h1234_5678);
        step();
        drive(1'b0, 0, 32'd0);
        chk("ex_op", {29'd0, bus.out_op}, 0);
        chk("ex_tag", {{(32-TAG_W){1'b0}}, bus.out_tag}, 32'h123);
        chk("ex_index", {{(32-INDEX_W){1'b0}}, bus.out_index}, 32'h1159);
        chk("ex_offset", {{(32-OFFSET_W){1'b0}}, bus.out_offset}, 32'h38);
        chk("ex_cnt_total", {16'd0, cnt_total}, 1);
        step();

        // Illegal code followed by print.
        do_reset();
        bus.out_ready = 1'b0;
        drive(1'b1, 7, $urandom);
        step();
        chk("ill_pulse", {31'd0, err_illegal}, 1);
        chk("ill_not_queued", {31'd0, bus.out_valid}, 0);
        drive(1'b1, 9, 32'd0);
        step();
        drive(1'b0, 0, 32'd0);
        chk("ill_pulse_end", {31'd0, err_illegal}, 0);
        chk("ill_cnt", {24'd0, cnt_illegal}, 1);
        chk("ill_print_op", {29'd0, bus.out_op}, 6);
        chk("ill_cnt_total", {16'd0, cnt_total}, 1);
        bus.out_ready = 1'b1;
        step();
        step();

        // Back-to-back fill with a stalled consumer, then release.
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, legal_codes[$urandom_range(0, 6)], $urandom);
            step();
        end
        chk("fill_cnt_total", {16'd0, cnt_total}, 4);
        chk("fill_in_ready", {31'd0, bus.in_ready}, 0);
        bus.out_ready = 1'b1;
        step();
        drive(1'b0, 0, 32'd0);
        for (int i = 0; i < 5; i++) step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
        end

        // Reset with two entries queued.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, legal_codes[$urandom_range(0, 6)], $urandom);
            step();
        end
        drive(1'b0, 0, 32'd0);
        chk("pre_rst_valid", {31'd0, bus.out_valid}, 1);
        do_reset();

        // Drain after end-of-file with three entries queued.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, legal_codes[$urandom_range(0, 6)], $urandom);
            step();
        end
        drive(1'b0, 0, 32'd0);
        bus.in_eof    = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && m_state != M_DONE; i++) step();
        chk("drain_done", {31'd0, done}, 1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, $urandom_range(0, 15), $urandom);
            step();
        end
        check_all();

        // Counter saturation.
        bus.in_eof = 1'b0;
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            drive(1'b1, legal_codes[$urandom_range(0, 6)], $urandom);
            step();
        end
        chk("sat_total", {16'd0, cnt_total}, 32'hFFFF);
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, illegal_codes[$urandom_range(0, 8)], $urandom);
            step();
        end
        chk("sat_illegal", {24'd0, cnt_illegal}, 32'hFF);
        drive(1'b0, 0, 32'd0);
        bus.in_eof = 1'b1;
        for (int i = 0; i < 10 && m_state != M_DONE; i++) step();
        chk("final_done", {31'd0, done}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
